// File: rtl/icache_assoc_param.sv
// icache_assoc_param: N-way set-associative instruction cache sitting between
// the IF stage and instruction memory. Hits are served combinationally; a miss
// stalls the CPU while a two-state FSM fetches one block from memory.
// Replacement is per-set round-robin, preferring invalid ways.
//
// Ports:
//   clock, reset          - system clock; asynchronous active-high reset
//   flush                 - synchronous pulse invalidating every line
//   pc_valid, pc          - fetch request and its byte address
//   instruction, busywait - fetched word and CPU stall
//   mem_read, mem_address - block read request and block address
//   mem_readdata          - refill block, word 0 in bits [31:0]
//   mem_busywait          - memory busy
//   hit_count, miss_count - wrapping performance counters
module icache_assoc_param #(
   parameter  int unsigned ADDR_W = 32,
   parameter  int unsigned SETS   = 8,
   parameter  int unsigned WAYS   = 2,
   parameter  int unsigned WORDS  = 4,
   parameter  int unsigned CNT_W  = 32,
   localparam int unsigned OFF_W  = $clog2(WORDS) + 2,
   localparam int unsigned IDX_W  = $clog2(SETS),
   localparam int unsigned TAG_W  = ADDR_W - OFF_W - IDX_W
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    flush,
   input  logic                    pc_valid,
   input  logic [ADDR_W-1:0]       pc,
   output logic [31:0]             instruction,
   output logic                    busywait,
   output logic                    mem_read,
   output logic [ADDR_W-OFF_W-1:0] mem_address,
   input  logic [32*WORDS-1:0]     mem_readdata,
   input  logic                    mem_busywait,
   output logic [CNT_W-1:0]        hit_count,
   output logic [CNT_W-1:0]        miss_count
);

   localparam int unsigned PTR_W  = (WAYS  > 1) ? $clog2(WAYS)  : 1;
   localparam int unsigned WSEL_W = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic {IDLE, MEM_READ} state_t;

   state_t                     state_q, state_d;
   logic [SETS-1:0][WAYS-1:0]  valid_q;
   logic [SETS-1:0][PTR_W-1:0] ptr_q;
   logic [TAG_W-1:0]           tag_q  [SETS][WAYS];
   logic [32*WORDS-1:0]        data_q [SETS][WAYS];
   logic [TAG_W-1:0]           miss_tag_q;
   logic [IDX_W-1:0]           miss_idx_q;
   logic                       flush_pend_q;
   logic [CNT_W-1:0]           hit_cnt_q, miss_cnt_q;

   logic [TAG_W-1:0]    tag;
   logic [IDX_W-1:0]    idx;
   logic [WSEL_W-1:0]   off;
   logic                way_match;
   logic [32*WORDS-1:0] hit_blk;
   logic                lookup_hit, lookup_miss, refill_done;
   logic [PTR_W-1:0]    victim, ptr_next;
   logic                victim_found;
   logic                unused_pc_lsb;

   assign tag = pc[ADDR_W-1:OFF_W+IDX_W];
   assign idx = pc[OFF_W+IDX_W-1:OFF_W];
   assign unused_pc_lsb = ^pc[1:0];

   generate
      if (WORDS > 1) begin : g_off
         assign off = pc[OFF_W-1:2];
      end else begin : g_off_single
         assign off = '0;
      end
   endgenerate

   // Tags within a set are unique, so at most one way matches.
   always_comb begin
      way_match = 1'b0;
      hit_blk   = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
            way_match = 1'b1;
            hit_blk   = data_q[idx][w];
         end
      end
   end

   assign lookup_hit  = pc_valid && (state_q == IDLE) && way_match;
   assign lookup_miss = pc_valid && (state_q == IDLE) && !way_match;
   assign refill_done = (state_q == MEM_READ) && !mem_busywait;

   // Lowest invalid way wins; otherwise fall back to the set's pointer.
   always_comb begin
      victim       = ptr_q[miss_idx_q];
      victim_found = 1'b0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!victim_found && !valid_q[miss_idx_q][w]) begin
            victim       = PTR_W'(w);
            victim_found = 1'b1;
         end
      end
   end

   // WAYS is a power of two, so wrapping in PTR_W bits is the modulo.
   assign ptr_next = (WAYS > 1) ? PTR_W'(victim + 1'b1) : '0;

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (lookup_miss)   state_d = MEM_READ;
         MEM_READ: if (!mem_busywait) state_d = IDLE;
         default:                     state_d = IDLE;
      endcase
   end

   // Outputs are forced low while reset is held, independent of pc_valid.
   always_comb begin
      instruction = '0;
      busywait    = 1'b0;
      mem_read    = 1'b0;
      mem_address = '0;
      if (!reset) begin
         if (state_q == MEM_READ) begin
            mem_read    = 1'b1;
            busywait    = 1'b1;
            mem_address = {miss_tag_q, miss_idx_q};
         end else if (lookup_hit) begin
            instruction = hit_blk[32*off +: 32];
         end else begin
            busywait = pc_valid;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         valid_q      <= '0;
         ptr_q        <= '0;
         miss_tag_q   <= '0;
         miss_idx_q   <= '0;
         flush_pend_q <= 1'b0;
         hit_cnt_q    <= '0;
         miss_cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (lookup_hit) hit_cnt_q <= hit_cnt_q + 1'b1;
         if (lookup_miss) begin
            miss_cnt_q <= miss_cnt_q + 1'b1;
            miss_tag_q <= tag;
            miss_idx_q <= idx;
         end
         if (state_q == IDLE) begin
            if (flush) begin
               valid_q <= '0;
               ptr_q   <= '0;
            end
         end else if (refill_done) begin
            // A flush seen during the refill also kills the line just written.
            flush_pend_q <= 1'b0;
            if (flush_pend_q || flush) begin
               valid_q <= '0;
               ptr_q   <= '0;
            end else begin
               valid_q[miss_idx_q][victim] <= 1'b1;
               ptr_q[miss_idx_q]           <= ptr_next;
            end
         end else if (flush) begin
            flush_pend_q <= 1'b1;
         end
      end
   end

   // Line payload needs no reset; the valid bits gate every use of it.
   always_ff @(posedge clock) begin
      if (refill_done) begin
         data_q[miss_idx_q][victim] <= mem_readdata;
         tag_q[miss_idx_q][victim]  <= miss_tag_q;
      end
   end

   assign hit_count  = hit_cnt_q;
   assign miss_count = miss_cnt_q;

endmodule

// File: tb/tb_icache_assoc_param.sv
// tb_icache_assoc_param: directed self-checking bench for icache_assoc_param
// with default parameters. A behavioural memory answers block reads after
// three busy cycles; each task drives one scenario and checks it inline.
module tb_icache_assoc_param;

   logic         clock = 1'b0;
   logic         reset, flush, pc_valid;
   logic [31:0]  pc;
   logic [31:0]  instruction;
   logic         busywait, mem_read, mem_busywait;
   logic [27:0]  mem_address;
   logic [127:0] mem_readdata;
   logic [31:0]  hit_count, miss_count;

   int unsigned vectors = 0;
   int unsigned errors  = 0;
   int          lat_cnt = 0;

   icache_assoc_param #(.ADDR_W(32), .SETS(8), .WAYS(2), .WORDS(4), .CNT_W(32)) dut (
      .clock        (clock),
      .reset        (reset),
      .flush        (flush),
      .pc_valid     (pc_valid),
      .pc           (pc),
      .instruction  (instruction),
      .busywait     (busywait),
      .mem_read     (mem_read),
      .mem_address  (mem_address),
      .mem_readdata (mem_readdata),
      .mem_busywait (mem_busywait),
      .hit_count    (hit_count),
      .miss_count   (miss_count)
   );

   always #5 clock = ~clock;

   // Memory: busy from the cycle mem_read rises for three cycles.
   always @(posedge clock) begin
      if (!mem_read) lat_cnt <= 0;
      else           lat_cnt <= lat_cnt + 1;
   end
   assign mem_busywait = mem_read && (lat_cnt < 3);

   function automatic logic [127:0] blk(input logic [27:0] a);
      logic [127:0] b;
      if (a == 28'h1) begin
         b = {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
      end else begin
         for (int j = 0; j < 4; j++) b[32*j +: 32] = {4'hA, a[23:0], 4'(j)};
      end
      return b;
   endfunction
   assign mem_readdata = blk(mem_address);

   // Observes a stall until busywait falls; gathers what happened on the way.
   task automatic wait_ready(output int stalls, output int mcyc, output int bursts,
                             output logic [27:0] maddr, output logic addr_ok);
      logic prev_rd, first;
      stalls = 0; mcyc = 0; bursts = 0; maddr = '0; addr_ok = 1'b1;
      prev_rd = 1'b0; first = 1'b1;
      while (busywait === 1'b1 && stalls < 60) begin
         stalls++;
         if (mem_read === 1'b1) begin
            mcyc++;
            if (!prev_rd) bursts++;
            if (first) begin maddr = mem_address; first = 1'b0; end
            else if (mem_address !== maddr) addr_ok = 1'b0;
         end
         prev_rd = mem_read;
         @(negedge clock); #1;
      end
      if (busywait !== 1'b0) stalls = -1;
   endtask

   // One fetch: present pc, wait for it to be served, one edge to count it, drop.
   task automatic do_access(input logic [31:0] a, output int st, output int mc,
                            output int nb, output logic [27:0] ma, output logic aok,
                            output logic [31:0] ins, output logic rd);
      @(negedge clock);
      pc = a; pc_valid = 1'b1;
      #1;
      wait_ready(st, mc, nb, ma, aok);
      ins = instruction;
      rd  = mem_read;
      @(negedge clock);
      pc_valid = 1'b0;
      #1;
   endtask

   int st, mc, nb;
   logic [27:0] ma;
   logic aok, rd;
   logic [31:0] ins;

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; pc_valid = 1'b0; pc = '0;
      #1;
      vectors++; if (busywait !== 1'b0) begin errors++; $display("FAIL rst_busywait: got %b expected 0", busywait); end
      vectors++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read: got %b expected 0", mem_read); end
      vectors++; if (mem_address !== 28'h0) begin errors++; $display("FAIL rst_mem_address: got %h expected 0", mem_address); end
      vectors++; if (instruction !== 32'h0) begin errors++; $display("FAIL rst_instruction: got %h expected 0", instruction); end
      vectors++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL rst_counters: got %0d/%0d expected 0/0", hit_count, miss_count); end
      repeat (2) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic test_miss_refill();
      do_access(32'h10, st, mc, nb, ma, aok, ins, rd);
      vectors++; if (st !== 5) begin errors++; $display("FAIL t1_stall_cycles: got %0d expected 5", st); end
      vectors++; if (mc !== 4 || nb !== 1) begin errors++; $display("FAIL t1_mem_read: got %0d cycles %0d bursts expected 4/1", mc, nb); end
      vectors++; if (ma !== 28'h1 || aok !== 1'b1) begin errors++; $display("FAIL t1_mem_address: got %h stable=%b expected 0000001 stable=1", ma, aok); end
      vectors++; if (ins !== 32'h11111111) begin errors++; $display("FAIL t1_instruction: got %h expected 11111111", ins); end
      vectors++; if (rd !== 1'b0) begin errors++; $display("FAIL t1_mem_read_drop: got %b expected 0", rd); end
      vectors++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin errors++; $display("FAIL t1_counters: got %0d/%0d expected 1/1", hit_count, miss_count); end
   endtask

   task automatic test_hit();
      do_access(32'h18, st, mc, nb, ma, aok, ins, rd);
      vectors++; if (st !== 0 || nb !== 0) begin errors++; $display("FAIL t2_zero_stall: got %0d stalls %0d reads expected 0/0", st, nb); end
      vectors++; if (ins !== 32'h33333333) begin errors++; $display("FAIL t2_instruction: got %h expected 33333333", ins); end
      vectors++; if (hit_count !== 32'd2 || miss_count !== 32'd1) begin errors++; $display("FAIL t2_counters: got %0d/%0d expected 2/1", hit_count, miss_count); end
   endtask

   task automatic test_replacement();
      do_access(32'h90, st, mc, nb, ma, aok, ins, rd);
      vectors++; if (st !== 5 || ma !== 28'h9) begin errors++; $display("FAIL t3_fill_090: got %0d stalls addr %h expected 5 addr 0000009", st, ma); end
      vectors++; if (ins !== 32'hA0000090) begin errors++; $display("FAIL t3_ins_090: got %h expected a0000090", ins); end
      do_access(32'h110, st, mc, nb, ma, aok, ins, rd);
      vectors++; if (st !== 5 || ma !== 28'h11) begin errors++; $display("FAIL t3_fill_110: got %0d stalls addr %h expected 5 addr 0000011", st, ma); end
      vectors++; if (ins !== 32'hA0000110) begin errors++; $display("FAIL t3_ins_110: got %h expected a0000110", ins); end
      do_access(32'h90, st, mc, nb, ma, aok, ins, rd);
      vectors++; if (st !== 0 || ins !== 32'hA0000090) begin errors++; $display("FAIL t3_hit_090: got %0d stalls ins %h expected 0 a0000090", st, ins); end
      do_access(32'h10, st, mc, nb, ma, aok, ins, rd);
      vectors++; if (st !== 5 || ma !== 28'h1) begin errors++; $display("FAIL t3_evicted_010: got %0d stalls addr %h expected 5 addr 0000001", st, ma); end
      vectors++; if (ins !== 32'h11111111) begin errors++; $display("FAIL t3_ins_010: got %h expected 11111111", ins); end
      vectors++; if (hit_count !== 32'd6 || miss_count !== 32'd4) begin errors++; $display("FAIL t3_counters: got %0d/%0d expected 6/4", hit_count, miss_count); end
   endtask

   task automatic test_flush_idle();
      @(negedge clock); flush = 1'b1;
      @(negedge clock); flush = 1'b0;
      #1;
      vectors++; if (hit_count !== 32'd6 || miss_count !== 32'd4) begin errors++; $display("FAIL t4_flush_counters: got %0d/%0d expected 6/4", hit_count, miss_count); end
      do_access(32'h90, st, mc, nb, ma, aok, ins, rd);
      vectors++; if (st !== 5 || ma !== 28'h9) begin errors++; $display("FAIL t4_miss_after_flush: got %0d stalls addr %h expected 5 addr 0000009", st, ma); end
      vectors++; if (hit_count !== 32'd7 || miss_count !== 32'd5) begin errors++; $display("FAIL t4_counters: got %0d/%0d expected 7/5", hit_count, miss_count); end
      // Flush coinciding with a hit: the hit is still served and counted.
      @(negedge clock); pc = 32'h90; pc_valid = 1'b1; flush = 1'b1;
      #1;
      vectors++; if (busywait !== 1'b0 || instruction !== 32'hA0000090) begin errors++; $display("FAIL t4_flush_hit: got busy %b ins %h expected 0 a0000090", busywait, instruction); end
      @(negedge clock); flush = 1'b0; pc_valid = 1'b0;
      #1;
      vectors++; if (hit_count !== 32'd8 || miss_count !== 32'd5) begin errors++; $display("FAIL t4_flush_hit_count: got %0d/%0d expected 8/5", hit_count, miss_count); end
      do_access(32'h90, st, mc, nb, ma, aok, ins, rd);
      vectors++; if (st !== 5 || miss_count !== 32'd6) begin errors++; $display("FAIL t4_flushed_again: got %0d stalls miss %0d expected 5/6", st, miss_count); end
   endtask

   task automatic test_flush_mem_read();
      @(negedge clock); pc = 32'h20; pc_valid = 1'b1;
      fork
         begin
            @(negedge clock); flush = 1'b1;
            @(negedge clock); flush = 1'b0;
         end
      join_none
      #1;
      wait_ready(st, mc, nb, ma, aok);
      ins = instruction;
      rd  = mem_read;
      @(negedge clock); pc_valid = 1'b0;
      #1;
      vectors++; if (nb !== 2 || mc !== 8) begin errors++; $display("FAIL t5_two_reads: got %0d bursts %0d cycles expected 2/8", nb, mc); end
      vectors++; if (st !== 10) begin errors++; $display("FAIL t5_stall_cycles: got %0d expected 10", st); end
      vectors++; if (ma !== 28'h2 || aok !== 1'b1 || rd !== 1'b0) begin errors++; $display("FAIL t5_address: got %h stable=%b rd=%b expected 0000002 1 0", ma, aok, rd); end
      vectors++; if (ins !== 32'hA0000020) begin errors++; $display("FAIL t5_instruction: got %h expected a0000020", ins); end
      vectors++; if (hit_count !== 32'd10 || miss_count !== 32'd8) begin errors++; $display("FAIL t5_counters: got %0d/%0d expected 10/8", hit_count, miss_count); end
   endtask

   task automatic test_reset_mid_refill();
      @(negedge clock); pc = 32'h10; pc_valid = 1'b1;
      @(negedge clock); #1;
      vectors++; if (mem_read !== 1'b1) begin errors++; $display("FAIL t6_in_refill: got %b expected 1", mem_read); end
      #1 reset = 1'b1;
      #1;
      vectors++; if (mem_read !== 1'b0 || busywait !== 1'b0) begin errors++; $display("FAIL t6_async_drop: got rd %b busy %b expected 0 0", mem_read, busywait); end
      vectors++; if (hit_count !== 32'd0 || miss_count !== 32'd0) begin errors++; $display("FAIL t6_counters_clear: got %0d/%0d expected 0/0", hit_count, miss_count); end
      @(negedge clock); reset = 1'b0;
      #1;
      wait_ready(st, mc, nb, ma, aok);
      ins = instruction;
      @(negedge clock); pc_valid = 1'b0;
      #1;
      vectors++; if (st !== 5 || ma !== 28'h1 || ins !== 32'h11111111) begin errors++; $display("FAIL t6_refetch: got %0d stalls addr %h ins %h expected 5 0000001 11111111", st, ma, ins); end
      vectors++; if (hit_count !== 32'd1 || miss_count !== 32'd1) begin errors++; $display("FAIL t6_counters: got %0d/%0d expected 1/1", hit_count, miss_count); end
   endtask

   initial begin
      test_reset();
      test_miss_refill();
      test_hit();
      test_replacement();
      test_flush_idle();
      test_flush_mem_read();
      test_reset_mid_refill();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
